// File: rtl/stopwatch_core.sv
// stopwatch_core
// Timekeeping stage of the stopwatch. Counts hundredths of a second as a
// 4-digit BCD SS.hh value (00.00 .. 59.99) from the clock-divider tick, under a
// run / stop / lap state machine driven by debounced buttons.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous active-high reset
//   tick_in     10 kHz square wave from the divider (asynchronous to clk)
//   btn_start   debounced start/stop level (asynchronous)
//   btn_lap     debounced lap level (asynchronous)
//   btn_clear   debounced clear level (asynchronous)
//   digits      {sec_tens, sec_ones, hun_tens, hun_ones}, BCD
//   running     high in RUN and LAP
//   lap_active  high in LAP
//   overflow    sticky, set on the 59.99 -> 00.00 wrap
module stopwatch_core #(
    parameter int TICKS_PER_HUNDREDTH = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(TICKS_PER_HUNDREDTH - 1);

    // Bit order of the conditioned inputs: {tick, start, lap, clear}
    logic [3:0] in_p0;
    logic [3:0] in_p1;
    logic [3:0] in_p2;
    logic       vld_p0;
    logic       vld_p1;
    logic       vld_p2;
    logic [3:0] evt;
    logic       tick_evt;
    logic       start_evt;
    logic       lap_evt;
    logic       clear_evt;

    state_t      state;
    state_t      state_nxt;
    logic        running_nxt;
    logic        lap_active_nxt;

    logic [15:0] presc;
    logic [15:0] count;
    logic [15:0] lap_reg;
    logic [16:0] count_inc;
    logic        count_en;
    logic        clear_go;
    logic        snap_go;

    // BCD increment with wrap; bit 16 flags the 59.99 -> 00.00 rollover.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic       wrap;
        d0   = v[3:0];
        d1   = v[7:4];
        d2   = v[11:8];
        d3   = v[15:12];
        wrap = 1'b0;
        if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 != 4'd9) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                if (d2 != 4'd9) begin
                    d2 = d2 + 4'd1;
                end else begin
                    d2 = 4'd0;
                    if (d3 != 4'd5) begin
                        d3 = d3 + 4'd1;
                    end else begin
                        d3   = 4'd0;
                        wrap = 1'b1;
                    end
                end
            end
        end
        return {wrap, d3, d2, d1, d0};
    endfunction

    // Stage p0/p1: two-flop synchronizer; p2: edge-history flop.
    // vld_pN tracks which stages hold post-reset samples. The edge detector is
    // held off until p2 has been refilled, so a level held high through reset
    // never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_p0  <= '0;
            in_p1  <= '0;
            in_p2  <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            in_p0  <= {tick_in, btn_start, btn_lap, btn_clear};
            in_p1  <= in_p0;
            in_p2  <= in_p1;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    assign evt       = in_p1 & ~in_p2 & {4{vld_p2}};
    assign tick_evt  = evt[3];
    assign start_evt = evt[2];
    assign lap_evt   = evt[1];
    assign clear_evt = evt[0];

    // State register; running/lap_active are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state      <= state_nxt;
            running    <= running_nxt;
            lap_active <= lap_active_nxt;
        end
    end

    // Next state. Priority clear > start > lap, but an event that is illegal in
    // the current state is skipped so the next legal one can act.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_evt) state_nxt = RUN;
            RUN: begin
                if (start_evt)    state_nxt = STOP;
                else if (lap_evt) state_nxt = LAP;
            end
            LAP: begin
                if (start_evt)    state_nxt = STOP;
                else if (lap_evt) state_nxt = RUN;
            end
            STOP: begin
                if (clear_evt)      state_nxt = IDLE;
                else if (start_evt) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state, registered in the state process.
    always_comb begin
        running_nxt    = (state_nxt == RUN) || (state_nxt == LAP);
        lap_active_nxt = (state_nxt == LAP);
    end

    // A tick counts only if the watch is running both before and after this
    // cycle's transition: a tick coinciding with stop or restart is dropped.
    assign count_en  = tick_evt && (state == RUN || state == LAP)
                                && (state_nxt == RUN || state_nxt == LAP);
    assign clear_go  = (state == STOP) && (state_nxt == IDLE);
    assign snap_go   = (state == RUN) && (state_nxt == LAP);
    assign count_inc = bcd_inc(count);

    // Prescaler, live count, lap snapshot (pre-increment value) and overflow.
    always_ff @(posedge clk) begin
        if (reset || clear_go) begin
            presc    <= '0;
            count    <= '0;
            lap_reg  <= '0;
            overflow <= 1'b0;
        end else begin
            if (snap_go) begin
                lap_reg <= count;
            end
            if (count_en) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    count <= count_inc[15:0];
                    if (count_inc[16]) begin
                        overflow <= 1'b1;
                    end
                end else begin
                    presc <= presc + 16'd1;
                end
            end
        end
    end

    assign digits = lap_active ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_core.sv
// Testbench for stopwatch_core. Two instances: dut0 with 4 ticks per
// hundredth, dut1 with 1 tick per hundredth. Stimulus pushes expected outputs
// into a scoreboard queue; a monitor pops and compares on the falling edge.
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  tick;
    logic [1:0]  b_start;
    logic [1:0]  b_lap;
    logic [1:0]  b_clear;
    logic [15:0] digits0;
    logic [15:0] digits1;
    logic        running0;
    logic        running1;
    logic        lap_active0;
    logic        lap_active1;
    logic        overflow0;
    logic        overflow1;

    always #5 clk = ~clk;

    stopwatch_core #(.TICKS_PER_HUNDREDTH(4)) dut0 (
        .clk(clk), .reset(reset), .tick_in(tick[0]),
        .btn_start(b_start[0]), .btn_lap(b_lap[0]), .btn_clear(b_clear[0]),
        .digits(digits0), .running(running0), .lap_active(lap_active0),
        .overflow(overflow0)
    );

    stopwatch_core #(.TICKS_PER_HUNDREDTH(1)) dut1 (
        .clk(clk), .reset(reset), .tick_in(tick[1]),
        .btn_start(b_start[1]), .btn_lap(b_lap[1]), .btn_clear(b_clear[1]),
        .digits(digits1), .running(running1), .lap_active(lap_active1),
        .overflow(overflow1)
    );

    typedef struct packed {
        logic        d;
        logic [15:0] dig;
        logic        run;
        logic        lap;
        logic        ovf;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    checks = 0;
    int    errors = 0;

    task automatic cmp(string name, string field, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t  e;
            string n;
            e = sb.pop_front();
            n = sb_name.pop_front();
            if (e.d == 1'b0) begin
                cmp(n, "digits",     digits0,            e.dig);
                cmp(n, "running",    {15'd0, running0},    {15'd0, e.run});
                cmp(n, "lap_active", {15'd0, lap_active0}, {15'd0, e.lap});
                cmp(n, "overflow",   {15'd0, overflow0},   {15'd0, e.ovf});
            end else begin
                cmp(n, "digits",     digits1,            e.dig);
                cmp(n, "running",    {15'd0, running1},    {15'd0, e.run});
                cmp(n, "lap_active", {15'd0, lap_active1}, {15'd0, e.lap});
                cmp(n, "overflow",   {15'd0, overflow1},   {15'd0, e.ovf});
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string name, int d, logic [15:0] dig, logic run, logic lap, logic ovf);
        exp_t e;
        e.d   = (d != 0);
        e.dig = dig;
        e.run = run;
        e.lap = lap;
        e.ovf = ovf;
        sb.push_back(e);
        sb_name.push_back(name);
        for (int i = 0; i < 4; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s monitor_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
            sb_name.delete();
        end
    endtask

    // Button levels held 3 clk (effect is visible after the third edge), then
    // released for 3 clk.
    task automatic press(int d, logic s, logic l, logic c);
        b_start[d] = s;
        b_lap[d]   = l;
        b_clear[d] = c;
        step(3);
        b_start[d] = 1'b0;
        b_lap[d]   = 1'b0;
        b_clear[d] = 1'b0;
        step(3);
    endtask

    task automatic ticks(int d, int n);
        repeat (n) begin
            tick[d] = 1'b1;
            step(2);
            tick[d] = 1'b0;
            step(2);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        tick    = '1;
        b_start = '1;
        b_lap   = '1;
        b_clear = '1;
        step(5);
        reset = 1'b0;
        chk("reset_release_0", 0, 16'h0000, 0, 0, 0);
        chk("reset_release_1", 1, 16'h0000, 0, 0, 0);
        step(8);
        chk("held_high_no_event_0", 0, 16'h0000, 0, 0, 0);
        chk("held_high_no_event_1", 1, 16'h0000, 0, 0, 0);
        tick    = '0;
        b_start = '0;
        b_lap   = '0;
        b_clear = '0;
        step(6);
        chk("release_no_event_0", 0, 16'h0000, 0, 0, 0);

        // IDLE ignores lap and clear
        press(0, 0, 1, 0);
        chk("idle_lap_ignored", 0, 16'h0000, 0, 0, 0);
        press(0, 0, 0, 1);
        chk("idle_clear_ignored", 0, 16'h0000, 0, 0, 0);

        // Basic count, 4 ticks per hundredth
        press(0, 1, 0, 0);
        chk("start_run", 0, 16'h0000, 1, 0, 0);
        ticks(0, 3);
        chk("three_ticks", 0, 16'h0000, 1, 0, 0);
        tick[0] = 1'b1;
        step(1);
        step(1);
        chk("fourth_tick_edge2", 0, 16'h0000, 1, 0, 0);
        step(1);
        chk("fourth_tick_edge3", 0, 16'h0001, 1, 0, 0);
        tick[0] = 1'b0;
        step(2);
        ticks(0, 36);
        chk("forty_ticks", 0, 16'h0010, 1, 0, 0);
        press(0, 1, 0, 0);
        chk("stop_holds", 0, 16'h0010, 0, 0, 0);
        press(0, 0, 1, 0);
        chk("stop_lap_ignored", 0, 16'h0010, 0, 0, 0);
        press(0, 0, 0, 1);
        chk("stop_clear_idle", 0, 16'h0000, 0, 0, 0);

        // Pause preserves the partial hundredth
        press(0, 1, 0, 0);
        ticks(0, 6);
        chk("pause_six_ticks", 0, 16'h0001, 1, 0, 0);
        press(0, 1, 0, 0);
        ticks(0, 10);
        chk("stopped_ticks_ignored", 0, 16'h0001, 0, 0, 0);
        press(0, 1, 0, 0);
        ticks(0, 2);
        chk("partial_preserved", 0, 16'h0002, 1, 0, 0);

        // Priority: clear+start in RUN -> start acts
        press(0, 1, 0, 1);
        chk("clear_start_in_run", 0, 16'h0002, 0, 0, 0);
        press(0, 0, 0, 1);
        chk("clear_after_stop", 0, 16'h0000, 0, 0, 0);
        press(0, 1, 0, 0);
        ticks(0, 4);
        chk("restart_count", 0, 16'h0001, 1, 0, 0);
        press(0, 0, 0, 1);
        chk("clear_in_run_ignored", 0, 16'h0001, 1, 0, 0);
        press(0, 1, 1, 0);
        chk("start_lap_in_run", 0, 16'h0001, 0, 0, 0);

        // Lap, 1 tick per hundredth
        press(1, 1, 0, 0);
        ticks(1, 12);
        chk("lap_pre", 1, 16'h0012, 1, 0, 0);
        press(1, 0, 1, 0);
        chk("lap_enter", 1, 16'h0012, 1, 1, 0);
        ticks(1, 30);
        chk("lap_frozen", 1, 16'h0012, 1, 1, 0);
        press(1, 0, 1, 0);
        chk("lap_exit_live", 1, 16'h0042, 1, 0, 0);
        press(1, 1, 0, 0);
        press(1, 0, 0, 1);
        chk("lap_clear", 1, 16'h0000, 0, 0, 0);

        // Wrap at 59.99
        press(1, 1, 0, 0);
        ticks(1, 5999);
        chk("count_5999", 1, 16'h5999, 1, 0, 0);
        ticks(1, 1);
        chk("wrap_6000", 1, 16'h0000, 1, 0, 1);
        ticks(1, 3);
        chk("overflow_sticky", 1, 16'h0003, 1, 0, 1);
        press(1, 1, 0, 0);
        chk("wrap_stop", 1, 16'h0003, 0, 0, 1);
        press(1, 0, 0, 1);
        chk("clear_overflow", 1, 16'h0000, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
